mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in EX next to the single-cycle ALU.
- Executes mult, multu, div, divu, mthi and mtlo; HI/LO are read directly by the datapath.
- Exposes `busy` so the hazard unit stalls md-class and HI/LO-reading instructions.

---
 rtl/mdu_unit.sv | 176 +++++++++++++++++
 tb/tb_mdu_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// Sits in EX beside the single-cycle ALU. mult/multu/div/divu are accepted
// when start=1 and busy=0; the result is computed into staging registers
// at acceptance and copied into HI/LO after a fixed number of busy cycles.
// mthi/mtlo write HI/LO directly at the accepting edge without going busy.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - request to execute mdOp this cycle
//   mdOp   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   SrcA   - rs operand / dividend / mthi-mtlo data
//   SrcB   - rt operand / divisor
//   busy   - long operation in progress (hazard unit stalls on this)
//   HI, LO - architectural HI/LO registers

module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [WIDTH-1:0]   hiNext, loNext;
  logic [WIDTH-1:0]   hiCalc, loCalc;
  logic               loadStage, commit, hiWrite, loWrite;

  logic [2*WIDTH-1:0] prodS, prodU;
  logic               divZero, negA, negB;
  logic [WIDTH-1:0]   magA, magB, magBSafe, divisorU;
  logic [WIDTH-1:0]   quoU, remU, quoM, remM, quoS, remS;

  // Datapath arithmetic. Signed division works on magnitudes and restores
  // the signs afterwards, so MIN/-1 naturally yields quotient MIN and
  // remainder 0. A zero divisor is replaced by 1 to keep the divider
  // well-defined; its result is overridden below anyway.
  always_comb begin
    prodS    = $signed({{WIDTH{SrcA[WIDTH-1]}}, SrcA}) *
               $signed({{WIDTH{SrcB[WIDTH-1]}}, SrcB});
    prodU    = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};
    divZero  = (SrcB == '0);
    negA     = SrcA[WIDTH-1];
    negB     = SrcB[WIDTH-1];
    magA     = negA ? -SrcA : SrcA;
    magB     = negB ? -SrcB : SrcB;
    magBSafe = divZero ? WIDTH'(1) : magB;
    divisorU = divZero ? WIDTH'(1) : SrcB;
    quoU     = SrcA / divisorU;
    remU     = SrcA % divisorU;
    quoM     = magA / magBSafe;
    remM     = magA % magBSafe;
    quoS     = (negA ^ negB) ? -quoM : quoM;
    remS     = negA ? -remM : remM;
  end

  // Select the HI/LO pair to stage for the requested long operation.
  always_comb begin
    hiCalc = '0;
    loCalc = '0;
    case (mdOp)
      OP_MULT: begin
        hiCalc = prodS[2*WIDTH-1:WIDTH];
        loCalc = prodS[WIDTH-1:0];
      end
      OP_MULTU: begin
        hiCalc = prodU[2*WIDTH-1:WIDTH];
        loCalc = prodU[WIDTH-1:0];
      end
      OP_DIV: begin
        hiCalc = divZero ? SrcA : remS;
        loCalc = divZero ? '1   : quoS;
      end
      OP_DIVU: begin
        hiCalc = divZero ? SrcA : remU;
        loCalc = divZero ? '1   : quoU;
      end
      default: begin
        hiCalc = '0;
        loCalc = '0;
      end
    endcase
  end

  // Control: in IDLE a start is decoded; long ops load the counter and go
  // BUSY, moves write HI/LO directly. In BUSY every start is ignored and
  // the counter runs down; the edge that sees cnt==1 commits the result,
  // which gives exactly LAT busy cycles.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    loadStage = 1'b0;
    commit    = 1'b0;
    hiWrite   = 1'b0;
    loWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT, OP_MULTU: begin
              loadStage = 1'b1;
              cntNext   = CNT_W'(MULT_CYCLES);
              stateNext = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              loadStage = 1'b1;
              cntNext   = CNT_W'(DIV_CYCLES);
              stateNext = BUSY;
            end
            OP_MTHI: hiWrite = 1'b1;
            OP_MTLO: loWrite = 1'b1;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  // State, counter, staging and architectural registers. Reset discards
  // any in-flight result along with the staging contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hiNext <= '0;
      loNext <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (loadStage) begin
        hiNext <= hiCalc;
        loNext <= loCalc;
      end
      if (commit) begin
        HI <= hiNext;
        LO <= loNext;
      end
      if (hiWrite) HI <= SrcA;
      if (loWrite) LO <= SrcA;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit (default parameters).
// Table of directed vectors, hand-written multi-cycle sequences and random
// operations checked against an arithmetic reference model.

module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] mHi = 32'h0;
  logic [31:0] mLo = 32'h0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdOp  (mdOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model computed with plain 64-bit arithmetic.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    lat = 0;
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = 5; end
      3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; lat = 5; end
      3'd3: begin
        lat = 10;
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd4: begin
        lat = 10;
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin q = ua / ub; r = ua % ub; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  // Drive one accepted request; returns #1 after the accepting edge with
  // operands scrambled to show they are not sampled afterwards.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mdOp  = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk); #1;
    start = 1'b0;
    mdOp  = 3'($urandom_range(0, 7));
    SrcA  = $urandom;
    SrcB  = $urandom;
  endtask

  // Count busy cycles (bounded) and check latency and final HI/LO.
  task automatic waitDone(input string name, input int expLat,
                          input logic [31:0] expHi, input logic [31:0] expLo);
    int cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
    end
    checkOutput({name, ".lat"}, 32'(cycles), 32'(expLat));
    checkOutput({name, ".hi"}, HI, expHi);
    checkOutput({name, ".lo"}, LO, expLo);
  endtask

  task automatic runOp(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int lat;
    refModel(op, a, b, mHi, mLo, lat);
    applyStimulus(op, a, b);
    waitDone(name, lat, mHi, mLo);
  endtask

  initial begin
    int cycles;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4] = '{3'd4, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 10};
    vecs[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6] = '{3'd5, 32'h0000AAAA, 32'h0,        32'h0000AAAA, 32'h80000000, 0};
    vecs[7] = '{3'd6, 32'h00005555, 32'h0,        32'h0000AAAA, 32'h00005555, 0};
    vecs[8] = '{3'd0, 32'h11111111, 32'h5,        32'h0000AAAA, 32'h00005555, 0};
    vecs[9] = '{3'd7, 32'h22222222, 32'h6,        32'h0000AAAA, 32'h00005555, 0};

    reset = 1'b1;
    start = 1'b0;
    mdOp  = 3'd0;
    SrcA  = 32'h0;
    SrcB  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.busy", 32'(busy), 32'h0);
    checkOutput("rst.hi", HI, 32'h0);
    checkOutput("rst.lo", LO, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone($sformatf("vec%0d", i), vecs[i].expLat, vecs[i].expHi, vecs[i].expLo);
      mHi = vecs[i].expHi;
      mLo = vecs[i].expLo;
    end

    // Starts while busy must be ignored entirely (a div and a mthi).
    refModel(3'd1, 32'd7, 32'd6, mHi, mLo, cycles);
    applyStimulus(3'd1, 32'd7, 32'd6);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 2) begin
        start = 1'b1; mdOp = 3'd3; SrcA = 32'd100; SrcB = 32'd3;
      end else if (cycles == 3) begin
        start = 1'b1; mdOp = 3'd5; SrcA = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("ign.lat", 32'(cycles), 32'd5);
    checkOutput("ign.hi", HI, 32'h0);
    checkOutput("ign.lo", LO, 32'd42);
    @(posedge clk); #1;
    checkOutput("ign.noqueue", 32'(busy), 32'h0);
    checkOutput("ign.hold", HI, 32'h0);

    // Reset in the fourth busy cycle of a div aborts it.
    runOp("pre.mthi", 3'd5, 32'h11112222, 32'h0);
    applyStimulus(3'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(busy), 32'h0);
    checkOutput("abort.hi", HI, 32'h0);
    checkOutput("abort.lo", LO, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mHi = 32'h0;
    mLo = 32'h0;
    repeat (12) begin @(posedge clk); #1; end
    checkOutput("post.busy", 32'(busy), 32'h0);
    checkOutput("post.hi", HI, 32'h0);
    checkOutput("post.lo", LO, 32'h0);
    runOp("reissue", 3'd3, 32'd100, 32'd7);

    // Back-to-back: second start in the cycle busy falls.
    runOp("b2b.first", 3'd2, 32'h89ABCDEF, 32'h12345678);
    applyStimulus(3'd3, 32'hFFFFFF00, 32'h7);
    checkOutput("b2b.rebusy", 32'(busy), 32'h1);
    refModel(3'd3, 32'hFFFFFF00, 32'h7, mHi, mLo, cycles);
    cycles = 1;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      if (busy) cycles++;
    end
    checkOutput("b2b.lat", 32'(cycles), 32'd10);
    checkOutput("b2b.hi", HI, mHi);
    checkOutput("b2b.lo", LO, mLo);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      runOp($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
